// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle ALU control unit.
// Covers the instruction field positions, opcodes, ALU select codes and controller states.
package cpu_pkg;

    // Instruction field bit positions: op[15:12] rd[11:10] rs[9:8] rt_imm[7:0], rt = rt_imm[1:0]
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int RT_MSB  = 1;
    localparam int RT_LSB  = 0;

    // Opcodes (0..5 are R-type and map straight onto the ALU select)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_J    = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation select encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_NOTB = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SRA1 = 3'b100;
    localparam logic [2:0] ALU_SLL1 = 3'b101;
    localparam logic [2:0] ALU_EQ   = 3'b110;
    localparam logic [2:0] ALU_NE   = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes C, D and E are unassigned
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

    // Ops whose ALU carry-out feeds the sticky overflow flag
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Counts consecutive enabled cycles and flags the last allowed one.
// o_expired is high in the LIMIT-th consecutive cycle of i_en; dropping i_en clears the count.
module timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    // Count enabled cycles, saturating at LIMIT-1 so the flag cannot wrap away
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            r_count <= '0;
        end else if (r_count != W'(LIMIT - 1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = i_en && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit: sequences each 16-bit instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the ALU, register file,
// data memory and PC strobes.
//
// Instruction handshake: an instruction transfers on a rising edge where both
// i_instr_valid and o_instr_ready are high. o_instr_ready is high only in FETCH;
// while it is low the producer must hold i_instr, and i_instr_valid is ignored.
//
// Output timing: datapath controls are decoded from the state and instruction
// registers. Decisions that depend on inputs (branch outcome, memory ack or
// abort) are registered, so o_pc_inc / o_pc_load pulse for one cycle in the
// cycle after the state that decided them. No input reaches an output
// combinationally.
module alu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    input  logic [15:0] i_instr,
    output logic        o_instr_ready,
    output logic [2:0]  o_alu_sel,
    output logic        o_alu_src_imm,
    input  logic        i_alu_ovf,
    input  logic        i_alu_take_branch,
    output logic [1:0]  o_rf_raddr_a,
    output logic [1:0]  o_rf_raddr_b,
    output logic [1:0]  o_rf_waddr,
    output logic        o_rf_we,
    output logic        o_rf_wsel_mem,
    output logic        o_mem_req,
    output logic        o_mem_we,
    input  logic        i_mem_ack,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic [7:0]  o_imm,
    output logic        o_ovf_flag,
    output logic        o_illegal,
    output logic        o_halted,
    output state_t      o_state
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;
    logic        r_pc_inc;
    logic        r_pc_load;
    logic        r_ovf_flag;
    logic        r_illegal;

    logic        w_ir_load;
    logic        w_pc_inc_nxt;
    logic        w_pc_load_nxt;
    logic        w_set_illegal;
    logic        w_set_ovf;
    logic        w_mem_expired;

    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [1:0]  w_rt;
    logic [7:0]  w_rt_imm;
    logic        w_is_branch;

    assign w_op        = r_ir[OP_MSB:OP_LSB];
    assign w_rd        = r_ir[RD_MSB:RD_LSB];
    assign w_rs        = r_ir[RS_MSB:RS_LSB];
    assign w_rt_imm    = r_ir[IMM_MSB:IMM_LSB];
    assign w_rt        = w_rt_imm[RT_MSB:RT_LSB];
    assign w_is_branch = is_branch_op(w_op);

    timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (r_state == ST_MEM),
        .o_expired (w_mem_expired)
    );

    // State, instruction register, registered PC pulses and sticky flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_FETCH;
            r_ir       <= '0;
            r_pc_inc   <= 1'b0;
            r_pc_load  <= 1'b0;
            r_ovf_flag <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_inc  <= w_pc_inc_nxt;
            r_pc_load <= w_pc_load_nxt;
            if (w_ir_load) begin
                r_ir <= i_instr;
            end
            if (w_set_ovf) begin
                r_ovf_flag <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and decision logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ir_load     = 1'b0;
        w_pc_inc_nxt  = 1'b0;
        w_pc_load_nxt = 1'b0;
        w_set_illegal = 1'b0;
        w_set_ovf     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (i_instr_valid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else if (is_illegal_op(w_op)) begin
                    w_set_illegal = 1'b1;
                    w_pc_inc_nxt  = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end else if (w_op == OP_J) begin
                    w_pc_load_nxt = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_set_ovf = is_arith_op(w_op) && i_alu_ovf;
                if (w_is_branch) begin
                    // Compare ops leave a stale ALU result: never write back
                    w_pc_load_nxt = i_alu_take_branch;
                    w_pc_inc_nxt  = !i_alu_take_branch;
                    w_state_nxt   = ST_FETCH;
                end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                // Ack takes priority over a simultaneous timeout
                if (i_mem_ack) begin
                    if (w_op == OP_LW) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        w_pc_inc_nxt = 1'b1;
                        w_state_nxt  = ST_FETCH;
                    end
                end else if (w_mem_expired) begin
                    w_set_illegal = 1'b1;
                    w_pc_inc_nxt  = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end
            end
            ST_WB: begin
                w_pc_inc_nxt = 1'b1;
                w_state_nxt  = ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Datapath controls decoded from state and instruction register
    always_comb begin
        o_alu_sel     = ALU_ADD;
        o_alu_src_imm = 1'b0;
        o_rf_raddr_a  = 2'd0;
        o_rf_raddr_b  = 2'd0;
        o_rf_waddr    = 2'd0;
        o_rf_we       = 1'b0;
        o_rf_wsel_mem = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_imm         = 8'd0;
        // Register addresses and immediate stay stable from DECODE through WB
        if ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
            (r_state == ST_MEM) || (r_state == ST_WB)) begin
            o_rf_raddr_a = w_is_branch ? w_rd : w_rs;
            o_rf_raddr_b = w_is_branch ? w_rs : w_rt;
            o_imm        = w_rt_imm;
        end
        case (r_state)
            ST_EXEC: begin
                // Ops 0..7 carry their ALU select in op[2:0]; ADDI/LW/SW add
                o_alu_sel     = w_op[3] ? ALU_ADD : w_op[2:0];
                o_alu_src_imm = (w_op == OP_ADDI) || (w_op == OP_LW) || (w_op == OP_SW);
            end
            ST_MEM: begin
                // Keep the address computation (rs + imm) steady while waiting
                o_alu_sel     = ALU_ADD;
                o_alu_src_imm = 1'b1;
                o_mem_req     = 1'b1;
                o_mem_we      = (w_op == OP_SW);
            end
            ST_WB: begin
                o_rf_we       = 1'b1;
                o_rf_waddr    = w_rd;
                o_rf_wsel_mem = (w_op == OP_LW);
            end
            default: begin
            end
        endcase
    end

    assign o_instr_ready = (r_state == ST_FETCH);
    assign o_halted      = (r_state == ST_HALT);
    assign o_pc_inc      = r_pc_inc;
    assign o_pc_load     = r_pc_load;
    assign o_ovf_flag    = r_ovf_flag;
    assign o_illegal     = r_illegal;
    assign o_state       = r_state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: hand-computed expectations for each
// instruction class, memory wait/abort, reset mid-instruction and HALT.
module tb_alu_ctrl_fsm;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_sel;
    logic        alu_src_imm;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic [1:0]  rf_raddr_a;
    logic [1:0]  rf_raddr_b;
    logic [1:0]  rf_waddr;
    logic        rf_we;
    logic        rf_wsel_mem;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  imm;
    logic        ovf_flag;
    logic        illegal;
    logic        halted;
    state_t      state;

    int n_total;
    int n_pass;
    int n_fail;
    int cnt;
    int we_cnt;
    int guard;

    alu_ctrl_fsm #(
        .MEM_TIMEOUT (15)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_instr_valid     (instr_valid),
        .i_instr           (instr),
        .o_instr_ready     (instr_ready),
        .o_alu_sel         (alu_sel),
        .o_alu_src_imm     (alu_src_imm),
        .i_alu_ovf         (alu_ovf),
        .i_alu_take_branch (alu_take_branch),
        .o_rf_raddr_a      (rf_raddr_a),
        .o_rf_raddr_b      (rf_raddr_b),
        .o_rf_waddr        (rf_waddr),
        .o_rf_we           (rf_we),
        .o_rf_wsel_mem     (rf_wsel_mem),
        .o_mem_req         (mem_req),
        .o_mem_we          (mem_we),
        .i_mem_ack         (mem_ack),
        .o_pc_inc          (pc_inc),
        .o_pc_load         (pc_load),
        .o_imm             (imm),
        .o_ovf_flag        (ovf_flag),
        .o_illegal         (illegal),
        .o_halted          (halted),
        .o_state           (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction in FETCH; returns sampled in DECODE
    task automatic issue(input logic [15:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    // Run the MEM phase, raising ack on the given MEM cycle (0 = never)
    task automatic run_mem(input int ack_on);
        cnt    = 0;
        we_cnt = 0;
        guard  = 0;
        while (state == ST_MEM && guard < 40) begin
            if (mem_req) cnt++;
            if (mem_we) we_cnt++;
            mem_ack = (ack_on != 0) && (cnt == ack_on);
            tick();
            guard++;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n           = 1'b0;
        instr_valid     = 1'b0;
        instr           = 16'h0000;
        alu_ovf         = 1'b0;
        alu_take_branch = 1'b0;
        mem_ack         = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_state", 16'(state), 16'(ST_FETCH));
        check("rst_instr_ready", 16'(instr_ready), 16'd1);
        check("rst_alu_sel", 16'(alu_sel), 16'd0);
        check("rst_rf_we", 16'(rf_we), 16'd0);
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_pc_inc", 16'(pc_inc), 16'd0);
        check("rst_pc_load", 16'(pc_load), 16'd0);
        check("rst_ovf", 16'(ovf_flag), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_imm", 16'(imm), 16'd0);
        rst_n = 1'b1;
        tick();
        check("idle_state", 16'(state), 16'(ST_FETCH));

        // ADD r1,r2,r3: rd=1 rs=2 rt=3
        issue(16'h0603);
        check("add_dec_state", 16'(state), 16'(ST_DECODE));
        check("add_dec_ready", 16'(instr_ready), 16'd0);
        check("add_dec_ra", 16'(rf_raddr_a), 16'd2);
        check("add_dec_rb", 16'(rf_raddr_b), 16'd3);
        check("add_dec_imm", 16'(imm), 16'h03);
        instr_valid = 1'b1;          // must be ignored outside FETCH
        instr       = 16'hF000;
        tick();
        check("add_exec_state", 16'(state), 16'(ST_EXEC));
        check("add_exec_sel", 16'(alu_sel), 16'd0);
        check("add_exec_srcimm", 16'(alu_src_imm), 16'd0);
        check("add_exec_we", 16'(rf_we), 16'd0);
        tick();
        instr_valid = 1'b0;
        instr       = 16'h0000;
        check("add_wb_state", 16'(state), 16'(ST_WB));
        check("add_wb_we", 16'(rf_we), 16'd1);
        check("add_wb_waddr", 16'(rf_waddr), 16'd1);
        check("add_wb_wsel", 16'(rf_wsel_mem), 16'd0);
        tick();
        check("add_ret_state", 16'(state), 16'(ST_FETCH));
        check("add_pc_inc", 16'(pc_inc), 16'd1);
        check("add_pc_load", 16'(pc_load), 16'd0);
        check("add_ret_we", 16'(rf_we), 16'd0);
        tick();
        check("add_pc_inc_pulse", 16'(pc_inc), 16'd0);

        // BEQ r1,r2 taken
        issue(16'h6600);
        check("beq_dec_ra", 16'(rf_raddr_a), 16'd1);
        check("beq_dec_rb", 16'(rf_raddr_b), 16'd2);
        tick();
        check("beq_exec_sel", 16'(alu_sel), 16'b110);
        alu_take_branch = 1'b1;
        tick();
        alu_take_branch = 1'b0;
        check("beq_ret_state", 16'(state), 16'(ST_FETCH));
        check("beq_pc_load", 16'(pc_load), 16'd1);
        check("beq_pc_inc", 16'(pc_inc), 16'd0);
        check("beq_we", 16'(rf_we), 16'd0);

        // BNE r2,r3 not taken
        issue(16'h7B00);
        check("bne_dec_ra", 16'(rf_raddr_a), 16'd2);
        check("bne_dec_rb", 16'(rf_raddr_b), 16'd3);
        tick();
        check("bne_exec_sel", 16'(alu_sel), 16'b111);
        tick();
        check("bne_ret_state", 16'(state), 16'(ST_FETCH));
        check("bne_pc_inc", 16'(pc_inc), 16'd1);
        check("bne_pc_load", 16'(pc_load), 16'd0);

        // ADDI r3,r0,0x7F with carry-out
        issue(16'h8C7F);
        check("addi_dec_imm", 16'(imm), 16'h7F);
        tick();
        check("addi_exec_srcimm", 16'(alu_src_imm), 16'd1);
        check("addi_exec_sel", 16'(alu_sel), 16'd0);
        check("addi_ovf_before", 16'(ovf_flag), 16'd0);
        alu_ovf = 1'b1;
        tick();
        alu_ovf = 1'b0;
        check("addi_wb_state", 16'(state), 16'(ST_WB));
        check("addi_ovf_set", 16'(ovf_flag), 16'd1);
        check("addi_wb_waddr", 16'(rf_waddr), 16'd3);
        tick();

        // AND r0,r1,r2: overflow stays sticky
        issue(16'h2102);
        tick();
        check("and_exec_sel", 16'(alu_sel), 16'b010);
        check("and_exec_srcimm", 16'(alu_src_imm), 16'd0);
        tick();
        tick();
        check("and_ret_state", 16'(state), 16'(ST_FETCH));
        check("and_ovf_sticky", 16'(ovf_flag), 16'd1);

        // LW r2,0x10(r1), ack on 4th MEM cycle; ack before MEM must be ignored
        mem_ack = 1'b1;
        issue(16'h9910);
        tick();
        check("lw_exec_state", 16'(state), 16'(ST_EXEC));
        check("lw_exec_srcimm", 16'(alu_src_imm), 16'd1);
        tick();
        mem_ack = 1'b0;
        check("lw_mem_state", 16'(state), 16'(ST_MEM));
        check("lw_mem_sel", 16'(alu_sel), 16'd0);
        check("lw_mem_ra", 16'(rf_raddr_a), 16'd1);
        run_mem(4);
        check("lw_mem_req_cycles", 16'(cnt), 16'd4);
        check("lw_mem_we_cycles", 16'(we_cnt), 16'd0);
        check("lw_wb_state", 16'(state), 16'(ST_WB));
        check("lw_wb_we", 16'(rf_we), 16'd1);
        check("lw_wb_wsel", 16'(rf_wsel_mem), 16'd1);
        check("lw_wb_waddr", 16'(rf_waddr), 16'd2);
        check("lw_wb_mem_req", 16'(mem_req), 16'd0);
        tick();
        check("lw_pc_inc", 16'(pc_inc), 16'd1);
        check("lw_illegal", 16'(illegal), 16'd0);

        // SW with no ack: aborts after 15 MEM cycles
        issue(16'hA104);
        tick();
        tick();
        run_mem(0);
        check("sw_req_cycles", 16'(cnt), 16'd15);
        check("sw_we_cycles", 16'(we_cnt), 16'd15);
        check("sw_abort_state", 16'(state), 16'(ST_FETCH));
        check("sw_abort_illegal", 16'(illegal), 16'd1);
        check("sw_abort_pc_inc", 16'(pc_inc), 16'd1);
        check("sw_abort_mem_req", 16'(mem_req), 16'd0);

        // Reset asserted during MEM
        issue(16'h9910);
        tick();
        tick();
        check("rstm_mem_req", 16'(mem_req), 16'd1);
        rst_n = 1'b0;
        tick();
        check("rstm_state", 16'(state), 16'(ST_FETCH));
        check("rstm_mem_req", 16'(mem_req), 16'd0);
        check("rstm_we", 16'(rf_we), 16'd0);
        check("rstm_illegal", 16'(illegal), 16'd0);
        check("rstm_ovf", 16'(ovf_flag), 16'd0);
        check("rstm_ready", 16'(instr_ready), 16'd1);
        rst_n = 1'b1;
        tick();

        // SW with ack on the timeout cycle: ack wins, no abort
        issue(16'hA104);
        tick();
        tick();
        run_mem(15);
        check("swack_req_cycles", 16'(cnt), 16'd15);
        check("swack_state", 16'(state), 16'(ST_FETCH));
        check("swack_illegal", 16'(illegal), 16'd0);
        check("swack_pc_inc", 16'(pc_inc), 16'd1);

        // Illegal opcode D
        issue(16'hD000);
        check("ill_dec_illegal", 16'(illegal), 16'd0);
        tick();
        check("ill_state", 16'(state), 16'(ST_FETCH));
        check("ill_illegal", 16'(illegal), 16'd1);
        check("ill_pc_inc", 16'(pc_inc), 16'd1);
        check("ill_pc_load", 16'(pc_load), 16'd0);

        // J 0x42
        issue(16'hB042);
        check("j_dec_imm", 16'(imm), 16'h42);
        tick();
        check("j_state", 16'(state), 16'(ST_FETCH));
        check("j_pc_load", 16'(pc_load), 16'd1);
        check("j_pc_inc", 16'(pc_inc), 16'd0);

        // HALT is terminal
        issue(16'hF000);
        tick();
        check("halt_state", 16'(state), 16'(ST_HALT));
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_ready", 16'(instr_ready), 16'd0);
        instr_valid = 1'b1;
        instr       = 16'h0603;
        mem_ack     = 1'b1;
        repeat (5) tick();
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        check("halt_stay_state", 16'(state), 16'(ST_HALT));
        check("halt_stay_halted", 16'(halted), 16'd1);
        check("halt_stay_ready", 16'(instr_ready), 16'd0);
        check("halt_we", 16'(rf_we), 16'd0);
        check("halt_mem_req", 16'(mem_req), 16'd0);
        check("halt_pc_inc", 16'(pc_inc), 16'd0);
        check("halt_pc_load", 16'(pc_load), 16'd0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
